regfile_wb_queue: RTL and testbench

REGFILE_WB_QUEUE -- requirements
Module: regfile_wb_queue

---
 rtl/regfile_wb_queue_if.sv | 36 +++
 rtl/regfile_wb_queue.sv | 114 +++++++++++
 tb/tb_regfile_wb_queue.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_queue_if.sv
// Write-back queue bus: producer handshake on the in_* side, register-file write port on the
// write_* side. The queue uses the slave modport; the producer/regfile model uses master.
interface regfile_wb_queue_if #(
  parameter int unsigned N = 16
) ();
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_addr;
  logic [N-1:0] in_data;
  logic         wb_stall;
  logic         write_enable;
  logic [2:0]   write_addr;
  logic [N-1:0] write_data;

  modport slave (
    input  in_valid,
    input  in_addr,
    input  in_data,
    input  wb_stall,
    output in_ready,
    output write_enable,
    output write_addr,
    output write_data
  );

  modport master (
    output in_valid,
    output in_addr,
    output in_data,
    output wb_stall,
    input  in_ready,
    input  write_enable,
    input  write_addr,
    input  write_data
  );
endinterface

// File: rtl/regfile_wb_queue.sv
// Register-file write-back queue: FIFO of {addr, data} results draining into one write port,
// with optional youngest-match forwarding enabled by the REGFILE_WB_FORWARD_EN macro.
module regfile_wb_queue #(
  parameter int unsigned N     = 16,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CntW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  regfile_wb_queue_if.slave wb,
  input  logic [2:0]        read_addr1,
  input  logic [2:0]        read_addr2,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [N-1:0]      fwd_data1,
  output logic [N-1:0]      fwd_data2,
  output logic [CntW-1:0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  // Entry storage is deliberately unreset; every read of it is gated by occupancy.
  logic [2:0]      mem_addr [DEPTH];
  logic [N-1:0]    mem_data [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic            not_empty;
  logic            push;
  logic            pop;

  // Handshake and write port depend only on registered occupancy plus wb_stall.
  assign not_empty       = (count_q != '0);
  assign wb.in_ready     = (count_q < CntW'(DEPTH));
  assign wb.write_enable = not_empty && !wb.wb_stall;
  assign wb.write_addr   = not_empty ? mem_addr[rd_ptr_q] : '0;
  assign wb.write_data   = not_empty ? mem_data[rd_ptr_q] : '0;
  assign count           = count_q;

  assign push = wb.in_valid && wb.in_ready;
  assign pop  = wb.write_enable;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr_q] <= wb.in_addr;
      mem_data[wr_ptr_q] <= wb.in_data;
    end
  end

`ifdef REGFILE_WB_FORWARD_EN
  // Scan oldest to youngest so a later match overrides; the head being written still counts.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CntW'(i) < count_q) begin
        if (mem_addr[rd_ptr_q + PtrW'(i)] == read_addr1) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = mem_data[rd_ptr_q + PtrW'(i)];
        end
        if (mem_addr[rd_ptr_q + PtrW'(i)] == read_addr2) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = mem_data[rd_ptr_q + PtrW'(i)];
        end
      end
    end
  end
`else
  logic unused_read_addr;
  assign unused_read_addr = ^{read_addr1, read_addr2};
  assign fwd_hit1  = 1'b0;
  assign fwd_hit2  = 1'b0;
  assign fwd_data1 = '0;
  assign fwd_data2 = '0;
`endif

`ifndef SYNTHESIS
  count_in_range: assert property (@(posedge clk) disable iff (rst) count_q <= CntW'(DEPTH));
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Self-checking bench for regfile_wb_queue: scenario tasks plus a scoreboard monitor that
// checks every register-file write against the order in which entries were accepted.
module tb_regfile_wb_queue;
  localparam int unsigned N     = 16;
  localparam int unsigned DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   read_addr1;
  logic [2:0]   read_addr2;
  logic         fwd_hit1;
  logic         fwd_hit2;
  logic [N-1:0] fwd_data1;
  logic [N-1:0] fwd_data2;
  logic [2:0]   count;

  regfile_wb_queue_if #(.N(N)) bus ();

  regfile_wb_queue #(.N(N), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .wb         (bus),
    .read_addr1 (read_addr1),
    .read_addr2 (read_addr2),
    .fwd_hit1   (fwd_hit1),
    .fwd_hit2   (fwd_hit2),
    .fwd_data1  (fwd_data1),
    .fwd_data2  (fwd_data2),
    .count      (count)
  );

  always #5 clk = ~clk;

`ifdef REGFILE_WB_FORWARD_EN
  localparam bit FwdEn = 1'b1;
`else
  localparam bit FwdEn = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [N+2:0] sb[$];
  logic [N+2:0] mon_exp;

  // Mid-cycle sampling: inputs change just after posedge, so these are the values the next
  // edge acts on. Pop is checked before push so a same-cycle push never matches itself.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (bus.write_enable) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL wb_unexpected: write addr=%0d data=%h while nothing pending",
                   bus.write_addr, bus.write_data);
        end else begin
          mon_exp = sb.pop_front();
          if ({bus.write_addr, bus.write_data} !== mon_exp) begin
            miscompares++;
            $display("FAIL wb_order: got addr=%0d data=%h, want addr=%0d data=%h",
                     bus.write_addr, bus.write_data, mon_exp[N+2:N], mon_exp[N-1:0]);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) sb.push_back({bus.in_addr, bus.in_data});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k = 0;
    bus.in_valid = 1'b0;
    bus.wb_stall = 1'b0;
    #1;
    while (count != 3'd0 && k < 20) begin
      step();
      k++;
    end
    vectors++;
    if (count !== 3'd0) begin
      miscompares++;
      $display("FAIL drain_timeout: count=%0d want 0 after %0d cycles", count, k);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_addr = 3'd2;
    bus.in_data = 16'h5555;
    bus.wb_stall = 1'b0;
    read_addr1 = 3'd2;
    read_addr2 = 3'd0;
    step();
    step();
    vectors++;
    if (count !== 3'd0) begin
      miscompares++; $display("FAIL reset_count: got %0d want 0", count);
    end
    vectors++;
    if ({bus.write_enable, bus.write_addr, bus.write_data} !== '0) begin
      miscompares++;
      $display("FAIL reset_write: got we=%b addr=%0d data=%h want all zero",
               bus.write_enable, bus.write_addr, bus.write_data);
    end
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_ready: got %b want 1", bus.in_ready);
    end
    vectors++;
    if ({fwd_hit1, fwd_hit2, fwd_data1, fwd_data2} !== '0) begin
      miscompares++;
      $display("FAIL reset_fwd: got hit=%b%b d1=%h d2=%h want zero",
               fwd_hit1, fwd_hit2, fwd_data1, fwd_data2);
    end
    bus.in_valid = 1'b0;
    rst = 1'b0;
    read_addr1 = 3'd0;
    step();
  endtask

  task automatic test_single();
    bus.in_valid = 1'b1;
    bus.in_addr = 3'd3;
    bus.in_data = 16'h00AA;
    step();
    bus.in_valid = 1'b0;
    #1;
    vectors++;
    if ({bus.write_enable, bus.write_addr, bus.write_data} !== {1'b1, 3'd3, 16'h00AA}) begin
      miscompares++;
      $display("FAIL single_write: got we=%b addr=%0d data=%h want we=1 addr=3 data=00aa",
               bus.write_enable, bus.write_addr, bus.write_data);
    end
    vectors++;
    if (count !== 3'd1) begin
      miscompares++; $display("FAIL single_count1: got %0d want 1", count);
    end
    step();
    vectors++;
    if (count !== 3'd0 || bus.write_enable !== 1'b0) begin
      miscompares++;
      $display("FAIL single_empty: got count=%0d we=%b want 0/0", count, bus.write_enable);
    end
  endtask

  task automatic test_stall_fill();
    bus.wb_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_addr = 3'(i + 1);
      bus.in_data = 16'hB000 + 16'(i);
      step();
    end
    bus.in_addr = 3'd7;
    bus.in_data = 16'hBEEF;
    #1;
    vectors++;
    if (count !== 3'd4 || bus.in_ready !== 1'b0 || bus.write_enable !== 1'b0) begin
      miscompares++;
      $display("FAIL full_state: got count=%0d ready=%b we=%b want 4/0/0",
               count, bus.in_ready, bus.write_enable);
    end
    step();
    vectors++;
    if (count !== 3'd4 || bus.write_addr !== 3'd1 || bus.write_data !== 16'hB000) begin
      miscompares++;
      $display("FAIL full_ignore: got count=%0d head=%0d/%h want 4 head=1/b000",
               count, bus.write_addr, bus.write_data);
    end
    bus.in_valid = 1'b0;
    bus.wb_stall = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({bus.write_enable, bus.write_addr, bus.write_data} !==
          {1'b1, 3'(i + 1), 16'hB000 + 16'(i)}) begin
        miscompares++;
        $display("FAIL release_write%0d: got we=%b addr=%0d data=%h want we=1 addr=%0d data=%h",
                 i, bus.write_enable, bus.write_addr, bus.write_data, i + 1, 16'hB000 + i);
      end
      step();
    end
    vectors++;
    if (count !== 3'd0 || bus.write_enable !== 1'b0) begin
      miscompares++;
      $display("FAIL release_empty: got count=%0d we=%b want 0/0", count, bus.write_enable);
    end
  endtask

  task automatic test_back_to_back();
    bus.wb_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_addr = 3'(i);
      bus.in_data = 16'hC000 + 16'(i);
      step();
    end
    bus.wb_stall = 1'b0;
    bus.in_data = 16'hC100;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b0 || bus.write_enable !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_full: got ready=%b we=%b want 0/1", bus.in_ready, bus.write_enable);
    end
    step();
    vectors++;
    if (count !== 3'd3 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_resume: got count=%0d ready=%b want 3/1", count, bus.in_ready);
    end
    for (int j = 0; j < 6; j++) begin
      bus.in_addr = 3'(j + 2);
      bus.in_data = 16'hC101 + 16'(j);
      step();
      vectors++;
      if (count !== 3'd3) begin
        miscompares++; $display("FAIL b2b_steady%0d: got count=%0d want 3", j, count);
      end
    end
    drain();
  endtask

  task automatic test_forward();
    bus.wb_stall = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_addr = 3'd5;
    bus.in_data = 16'h1111;
    step();
    bus.in_data = 16'h2222;
    step();
    bus.in_valid = 1'b0;
    read_addr1 = 3'd5;
    read_addr2 = 3'd6;
    #1;
    vectors++;
    if (fwd_hit1 !== FwdEn || fwd_data1 !== (FwdEn ? 16'h2222 : 16'h0000)) begin
      miscompares++;
      $display("FAIL fwd_youngest: got hit=%b data=%h want hit=%b data=%h",
               fwd_hit1, fwd_data1, FwdEn, FwdEn ? 16'h2222 : 16'h0000);
    end
    vectors++;
    if (fwd_hit2 !== 1'b0 || fwd_data2 !== 16'h0000) begin
      miscompares++;
      $display("FAIL fwd_nomatch: got hit=%b data=%h want 0/0000", fwd_hit2, fwd_data2);
    end
    bus.in_valid = 1'b1;
    bus.in_addr = 3'd6;
    bus.in_data = 16'h3333;
    #1;
    vectors++;
    if (fwd_hit2 !== 1'b0 || fwd_data2 !== 16'h0000) begin
      miscompares++;
      $display("FAIL fwd_inflight: got hit=%b data=%h want 0/0000", fwd_hit2, fwd_data2);
    end
    step();
    bus.in_valid = 1'b0;
    #1;
    vectors++;
    if (fwd_hit2 !== FwdEn || fwd_data2 !== (FwdEn ? 16'h3333 : 16'h0000)) begin
      miscompares++;
      $display("FAIL fwd_pushed: got hit=%b data=%h want hit=%b", fwd_hit2, fwd_data2, FwdEn);
    end
    bus.wb_stall = 1'b0;
    step();
    step();
    // Only {6,3333} remains and is being written; stale addr-5 storage must not hit.
    vectors++;
    if (count !== 3'd1 || bus.write_enable !== 1'b1 || fwd_hit1 !== 1'b0 ||
        fwd_data1 !== 16'h0000) begin
      miscompares++;
      $display("FAIL fwd_stale: got count=%0d we=%b hit1=%b d1=%h want 1/1/0/0000",
               count, bus.write_enable, fwd_hit1, fwd_data1);
    end
    vectors++;
    if (fwd_hit2 !== FwdEn || fwd_data2 !== (FwdEn ? 16'h3333 : 16'h0000)) begin
      miscompares++;
      $display("FAIL fwd_head: got hit=%b data=%h want hit=%b", fwd_hit2, fwd_data2, FwdEn);
    end
    step();
    vectors++;
    if (count !== 3'd0 || fwd_hit2 !== 1'b0) begin
      miscompares++;
      $display("FAIL fwd_drained: got count=%0d hit2=%b want 0/0", count, fwd_hit2);
    end
    read_addr1 = 3'd0;
    read_addr2 = 3'd0;
  endtask

  task automatic test_reset_mid();
    bus.wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_addr = 3'(i + 4);
      bus.in_data = 16'hE000 + 16'(i);
      step();
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    bus.wb_stall = 1'b0;
    #1;
    vectors++;
    if (count !== 3'd0 || bus.write_enable !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_during: got count=%0d we=%b ready=%b want 0/0/1",
               count, bus.write_enable, bus.in_ready);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (count !== 3'd0 || bus.write_enable !== 1'b0) begin
        miscompares++;
        $display("FAIL rstmid_after%0d: got count=%0d we=%b want 0/0",
                 i, count, bus.write_enable);
      end
    end
  endtask

  task automatic test_wrap();
    bus.wb_stall = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_addr = 3'(i);
      bus.in_data = 16'hD000 + 16'(i);
      step();
      vectors++;
      if (count !== 3'd1) begin
        miscompares++; $display("FAIL wrap_count%0d: got %0d want 1", i, count);
      end
    end
    bus.in_valid = 1'b0;
    step();
    vectors++;
    if (count !== 3'd0) begin
      miscompares++; $display("FAIL wrap_empty: got %0d want 0", count);
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_leftover: got %0d entries never written, want 0", sb.size());
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_addr = 3'd0;
    bus.in_data = '0;
    bus.wb_stall = 1'b0;
    read_addr1 = 3'd0;
    read_addr2 = 3'd0;
    rst = 1'b1;
    test_reset();
    test_single();
    test_stall_fill();
    test_back_to_back();
    test_forward();
    test_reset_mid();
    test_wrap();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
